regfile_wr_arbiter: RTL and testbench

Arbitrates the single register-file write port of the 32-bit MIPS core among four write-back requesters: 0 = ALU, 1 = load unit, 2 = mult/div move unit, 3 = link (jal/jalr, $31). Each cycle the block picks one valid requester and registers the winner's 2-bit select. The block drives its own `mux4to1_5bit` instance for the destination address and exports the select so the matching 32-bit data mux stays in lockstep. It sits between the pipeline write-back stage and the register file.

---
 rtl/regfile_wr_arbiter_pkg.sv | 19 +
 rtl/regfile_wr_arbiter_mux4to1_5bit.sv | 23 ++
 rtl/regfile_wr_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: requester indices
// and the architecturally special register numbers.
package regfile_wr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] REQ_ALU  = 2'd0;
  localparam logic [1:0] REQ_LOAD = 2'd1;
  localparam logic [1:0] REQ_MDU  = 2'd2;
  localparam logic [1:0] REQ_LINK = 2'd3;

  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] LINK_REG = 5'd31;

  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_mux4to1_5bit.sv
// 4:1 multiplexer for 5-bit register numbers, selected by {s1,s0}.
module mux4to1_5bit
  import regfile_wr_arbiter_pkg::*;
(
  input  logic       s0,
  input  logic       s1,
  input  logic [4:0] i0,
  input  logic [4:0] i1,
  input  logic [4:0] i2,
  input  logic [4:0] i3,
  output logic [4:0] y
);

  always_comb begin
    case ({s1, s0})
      REQ_ALU:  y = i0;
      REQ_LOAD: y = i1;
      REQ_MDU:  y = i2;
      default:  y = i3;
    endcase
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Picks one of four write-back requesters per cycle for the single register
// file write port; registers the winner's select and write strobe.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = 1,
  parameter int ZERO_FILTER   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_valid,
  input  logic [4:0] req_addr0,
  input  logic [4:0] req_addr1,
  input  logic [4:0] req_addr2,
  input  logic [4:0] req_addr3,
  input  logic       wb_stall,
  output logic [3:0] req_ready,
  output logic       sel_s0,
  output logic       sel_s1,
  output logic       wr_en,
  output logic [4:0] wr_addr
);

  logic [1:0] ptr;
  logic [1:0] gnt_idx_p0;
  logic       vld_p0;
  logic       acc_p0;
  logic       drop_p0;
  logic [4:0] gnt_addr_p0;
  logic [1:0] sel_p1;
  logic       vld_p1;

  // Stage p0: search from ptr, wrapping 3 -> 0; ptr stays 0 in fixed mode
  always_comb begin
    logic [1:0] cand;
    cand       = ptr;
    gnt_idx_p0 = ptr;
    vld_p0     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + 2'(k);
      if (!vld_p0 && req_valid[cand]) begin
        vld_p0     = 1'b1;
        gnt_idx_p0 = cand;
      end
    end
  end

  assign acc_p0    = vld_p0 & ~wb_stall & ~reset;
  assign req_ready = acc_p0 ? idx_onehot(gnt_idx_p0) : 4'b0000;

  always_comb begin
    case (gnt_idx_p0)
      REQ_ALU:  gnt_addr_p0 = req_addr0;
      REQ_LOAD: gnt_addr_p0 = req_addr1;
      REQ_MDU:  gnt_addr_p0 = req_addr2;
      default:  gnt_addr_p0 = req_addr3;
    endcase
  end

  // Writes to $zero are still accepted (and advance ptr), just not strobed
  assign drop_p0 = (ZERO_FILTER != 0) && (gnt_addr_p0 == ZERO_REG);

  // Stage p1: output register, frozen while the register file stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= REQ_ALU;
      vld_p1 <= 1'b0;
      sel_p1 <= REQ_ALU;
    end else if (!wb_stall) begin
      vld_p1 <= acc_p0 & ~drop_p0;
      if (acc_p0) begin
        sel_p1 <= gnt_idx_p0;
        if (PRIORITY_MODE != 0) begin
          ptr <= gnt_idx_p0 + 2'd1;
        end
      end
    end
  end

  assign sel_s0 = sel_p1[0];
  assign sel_s1 = sel_p1[1];
  assign wr_en  = vld_p1;

  mux4to1_5bit u_addr_mux (
    .s0 (sel_s0),
    .s1 (sel_s1),
    .i0 (req_addr0),
    .i1 (req_addr1),
    .i2 (req_addr2),
    .i3 (req_addr3),
    .y  (wr_addr)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: a round-robin/zero-filter instance and a
// fixed-priority/no-filter instance share stimulus and a reference model.
module tb_regfile_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_stall;
  logic [3:0] req_valid;
  logic [4:0] a0, a1, a2, a3;
  logic [4:0] na0, na1, na2, na3;

  logic [3:0] rdy_rr, rdy_fx;
  logic       s0_rr, s1_rr, s0_fx, s1_fx, wen_rr, wen_fx;
  logic [4:0] wa_rr, wa_fx;

  int total = 0;
  int bad   = 0;

  // model state: index 0 = round-robin/filter instance, 1 = fixed/no-filter
  int mptr[2];
  int mwen[2];
  int msel[2];

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       st;
    logic [3:0] rdy;
    logic       wen;
    logic [1:0] sel;
    logic [4:0] addr;
  } vec_t;

  vec_t tbl[23];

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.PRIORITY_MODE(1), .ZERO_FILTER(1)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(a0), .req_addr1(a1), .req_addr2(a2), .req_addr3(a3),
    .wb_stall(wb_stall), .req_ready(rdy_rr), .sel_s0(s0_rr), .sel_s1(s1_rr),
    .wr_en(wen_rr), .wr_addr(wa_rr)
  );

  regfile_wr_arbiter #(.PRIORITY_MODE(0), .ZERO_FILTER(0)) dut_fx (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(a0), .req_addr1(a1), .req_addr2(a2), .req_addr3(a3),
    .wb_stall(wb_stall), .req_ready(rdy_fx), .sel_s0(s0_fx), .sel_s1(s1_fx),
    .wr_en(wen_fx), .wr_addr(wa_fx)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int addr_of(input int i);
    case (i)
      0:       return int'(a0);
      1:       return int'(a1);
      2:       return int'(a2);
      default: return int'(a3);
    endcase
  endfunction

  // first valid requester scanning upward from p, modulo 4; -1 if none
  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic cyc(input logic rst, input logic [3:0] v, input logic st);
    int    w;
    int    exp_rdy;
    string pre;
    @(negedge clk);
    reset = rst; req_valid = v; wb_stall = st;
    a0 = na0; a1 = na1; a2 = na2; a3 = na3;
    #1;
    for (int j = 0; j < 2; j++) begin
      pre     = (j == 0) ? "rr" : "fx";
      w       = winner(v, mptr[j]);
      exp_rdy = (rst || st || w < 0) ? 0 : (1 << w);
      chk({pre, "_ready"}, int'(j == 0 ? rdy_rr : rdy_fx), exp_rdy);
      chk({pre, "_wr_en"}, int'(j == 0 ? wen_rr : wen_fx), mwen[j]);
      chk({pre, "_sel"}, int'(j == 0 ? {s1_rr, s0_rr} : {s1_fx, s0_fx}), msel[j]);
      chk({pre, "_wr_addr"}, int'(j == 0 ? wa_rr : wa_fx), addr_of(msel[j]));
      if (rst) begin
        mptr[j] = 0; mwen[j] = 0; msel[j] = 0;
      end else if (!st) begin
        if (w < 0) begin
          mwen[j] = 0;
        end else begin
          msel[j] = w;
          mwen[j] = (j == 0 && addr_of(w) == 0) ? 0 : 1;
          if (j == 0) mptr[j] = (w + 1) % 4;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; wb_stall = 1'b0; req_valid = 4'b1111;
    na0 = 5'd5; na1 = 5'd7; na2 = 5'd0; na3 = 5'd31;
    a0 = na0; a1 = na1; a2 = na2; a3 = na3;
    for (int j = 0; j < 2; j++) begin
      mptr[j] = 0; mwen[j] = 0; msel[j] = 0;
    end

    //           rst   valid    stall ready    wen   sel   wr_addr
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd5};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd5};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, 5'd5};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd0, 5'd5};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd1, 5'd7};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd2, 5'd0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd3, 5'd31};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd0, 5'd5};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd1, 5'd7};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd2, 5'd0};
    tbl[10] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd3, 5'd31};
    tbl[11] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b0, 2'd2, 5'd0};
    tbl[12] = '{1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd0, 5'd5};
    tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd7};
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd7};
    tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd7};
    tbl[16] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd1, 5'd7};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 5'd0};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 5'd0};
    tbl[19] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd2, 5'd0};
    tbl[20] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd7};
    tbl[21] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1, 5'd7};
    tbl[22] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 5'd5};

    @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].st);
      chk($sformatf("tbl%0d_ready", i), int'(rdy_rr), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_wr_en", i), int'(wen_rr), int'(tbl[i].wen));
      chk($sformatf("tbl%0d_sel", i), int'({s1_rr, s0_rr}), int'(tbl[i].sel));
      chk($sformatf("tbl%0d_wr_addr", i), int'(wa_rr), int'(tbl[i].addr));
    end

    // fixed priority: req1 wins every cycle while it stays valid
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'b1110, 1'b0);
      chk("fixed_ready", int'(rdy_fx), 2);
      if (i > 0) chk("fixed_sel", int'({s1_fx, s0_fx}), 1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) na0 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 4) == 0) na1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 4) == 0) na2 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 4) == 0) na3 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      cyc(($urandom_range(0, 31) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
